// File: rtl/mem_arb_if.sv
// Bus bundle between NCH core channels, the shared-memory arbiter and the memory.
// Handshake: a request transfers in any cycle where req && rdy are both high;
// a requester keeps req, address and data stable until it sees rdy. Read
// responses carry no ready: ch_rvalid is a one-cycle, one-hot strobe.
interface mem_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 15,
  parameter int DW  = 16
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    ch_rreq;
  logic [NCH*AW-1:0] ch_raddr;
  logic [NCH-1:0]    ch_rrdy;
  logic [NCH-1:0]    ch_rvalid;
  logic [DW-1:0]     ch_rdata;
  logic [NCH-1:0]    ch_wreq;
  logic [NCH*AW-1:0] ch_waddr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_wrdy;
  logic [AW-1:0]     mem_raddr;
  logic [DW-1:0]     mem_rdata;
  logic              mem_wen;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  // Round-robin pointers, exported so checkers can observe arbiter state
  logic [PW-1:0]     dbg_rr_ptr;
  logic [PW-1:0]     dbg_wr_ptr;

  modport slave (
    input  ch_rreq, ch_raddr, ch_wreq, ch_waddr, ch_wdata, mem_rdata,
    output ch_rrdy, ch_rvalid, ch_rdata, ch_wrdy,
    output mem_raddr, mem_wen, mem_waddr, mem_wdata,
    output dbg_rr_ptr, dbg_wr_ptr
  );

  modport master (
    output ch_rreq, ch_raddr, ch_wreq, ch_waddr, ch_wdata, mem_rdata,
    input  ch_rrdy, ch_rvalid, ch_rdata, ch_wrdy,
    input  mem_raddr, mem_wen, mem_waddr, mem_wdata,
    input  dbg_rr_ptr, dbg_wr_ptr
  );
endinterface

// File: rtl/mem_arb.sv
// Shared-memory arbiter: independent round-robin read and write arbiters in
// front of one memory, with a channel-ID delay line that routes each read
// response back to its requester RLAT cycles after acceptance.
module mem_arb #(
  parameter int NCH  = 2,
  parameter int AW   = 15,
  parameter int DW   = 16,
  parameter int RLAT = 1
) (
  input logic      clk,
  input logic      rst_n,
  mem_arb_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Returns {hit, channel}: lowest requester at or above ptr, else lowest overall.
  function automatic logic [PW:0] rr_pick(input logic [NCH-1:0] req,
                                          input logic [PW-1:0]  ptr);
    logic          lo_hit;
    logic          hi_hit;
    logic [PW-1:0] lo_g;
    logic [PW-1:0] hi_g;
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_g   = '0;
    hi_g   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_g   = PW'(i);
        if (PW'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_g   = PW'(i);
        end
      end
    end
    if (hi_hit) return {1'b1, hi_g};
    return {lo_hit, lo_g};
  endfunction

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [RLAT-1:0]          dl_vld_q, dl_vld_d;
  logic [RLAT-1:0][PW-1:0]  dl_id_q, dl_id_d;

  logic                     rgnt, wgnt;
  logic [PW-1:0]            rg, wg;
  logic [NCH-1:0]           rrdy, wrdy, rvalid;
  logic [AW-1:0]            raddr, waddr;
  logic [DW-1:0]            wdata, rdata;

  // Pick one read and one write winner; no grants while reset is asserted
  always_comb begin
    {rgnt, rg} = rr_pick(bus.ch_rreq, rr_ptr_q);
    {wgnt, wg} = rr_pick(bus.ch_wreq, wr_ptr_q);
    if (!rst_n) begin
      rgnt = 1'b0;
      wgnt = 1'b0;
    end
  end

  // Steer the winners' address/data to the memory and raise their ready
  always_comb begin
    rrdy  = '0;
    wrdy  = '0;
    raddr = '0;
    waddr = '0;
    wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rgnt && rg == PW'(i)) begin
        rrdy[i] = 1'b1;
        raddr   = bus.ch_raddr[i*AW +: AW];
      end
      if (wgnt && wg == PW'(i)) begin
        wrdy[i] = 1'b1;
        waddr   = bus.ch_waddr[i*AW +: AW];
        wdata   = bus.ch_wdata[i*DW +: DW];
      end
    end
  end

  // Advance pointers past each winner and shift the response delay line
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rgnt) rr_ptr_d = (rg == PW'(NCH - 1)) ? '0 : rg + 1'b1;
    if (wgnt) wr_ptr_d = (wg == PW'(NCH - 1)) ? '0 : wg + 1'b1;
    dl_vld_d    = '0;
    dl_id_d     = '0;
    dl_vld_d[0] = rgnt;
    dl_id_d[0]  = rg;
    for (int s = 1; s < RLAT; s++) begin
      dl_vld_d[s] = dl_vld_q[s-1];
      dl_id_d[s]  = dl_id_q[s-1];
    end
  end

  // State registers; reset drops any reads still in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      dl_vld_q <= '0;
      dl_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      dl_vld_q <= dl_vld_d;
      dl_id_q  <= dl_id_d;
    end
  end

  // Route memory read data to the channel recorded in the last stage
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rst_n && dl_vld_q[RLAT-1]) begin
      rdata = bus.mem_rdata;
      for (int i = 0; i < NCH; i++) begin
        if (dl_id_q[RLAT-1] == PW'(i)) rvalid[i] = 1'b1;
      end
    end
  end

  assign bus.ch_rrdy    = rrdy;
  assign bus.ch_wrdy    = wrdy;
  assign bus.ch_rvalid  = rvalid;
  assign bus.ch_rdata   = rdata;
  assign bus.mem_raddr  = raddr;
  assign bus.mem_wen    = wgnt;
  assign bus.mem_waddr  = waddr;
  assign bus.mem_wdata  = wdata;
  assign bus.dbg_rr_ptr = rr_ptr_q;
  assign bus.dbg_wr_ptr = wr_ptr_q;
endmodule
